// File: rtl/ascii_scroll_display.sv
// ascii_scroll_display: collects an ASCII message into a small buffer and
// presents it on a row of active-low 7-segment digits, either static,
// scrolling through the message, or blinking.
module ascii_scroll_display #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned MSG_DEPTH  = 16,
  parameter int unsigned CLK_DIV    = 25_000_000,
  parameter int unsigned BLINK_DIV  = 12_500_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              char_in,
  input  logic                    char_valid,
  output logic                    char_ready,
  input  logic                    commit,
  input  logic                    clear,
  input  logic [1:0]              mode,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    busy
);

  localparam int unsigned HEX_W   = 7 * NUM_DIGITS;
  localparam int unsigned DIV_MAX = (CLK_DIV > BLINK_DIV) ? CLK_DIV : BLINK_DIV;
  localparam int unsigned TICK_W  = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int unsigned LEN_W   = (MSG_DEPTH > 0) ? $clog2(MSG_DEPTH + 1) : 1;
  localparam int unsigned IDX_W   = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
  localparam int unsigned OFF_W   = ((MSG_DEPTH + NUM_DIGITS) > 1) ?
                                    $clog2(MSG_DEPTH + NUM_DIGITS) : 1;

  localparam logic [1:0] MODE_SCROLL = 2'b01;
  localparam logic [1:0] MODE_BLINK  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SHOW = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [OFF_W-1:0]   off_q, off_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic               phase_q, phase_d;   // 1 = blank half of the blink cycle
  logic [1:0]         mode_q;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic [HEX_W-1:0]   hex_q, hex_d;
  logic [7:0]         buf_q [MSG_DEPTH];

  logic               xfer;
  logic               wr_en;

  // Segment pattern (active-low, bit0=a .. bit6=g); letters fold to upper case.
  function automatic logic [6:0] glyph(input logic [7:0] c);
    logic [7:0] u;
    u = ((c >= 8'h61) && (c <= 8'h7A)) ? (c - 8'h20) : c;
    case (u)
      8'h00, 8'h30: glyph = 7'h40;
      8'h01, 8'h31: glyph = 7'h79;
      8'h02, 8'h32: glyph = 7'h24;
      8'h03, 8'h33: glyph = 7'h30;
      8'h04, 8'h34: glyph = 7'h19;
      8'h05, 8'h35: glyph = 7'h12;
      8'h06, 8'h36: glyph = 7'h02;
      8'h07, 8'h37: glyph = 7'h78;
      8'h08, 8'h38: glyph = 7'h00;
      8'h09, 8'h39: glyph = 7'h10;
      8'h41:        glyph = 7'h08;  // A
      8'h42:        glyph = 7'h03;  // b
      8'h43:        glyph = 7'h46;  // C
      8'h44:        glyph = 7'h21;  // d
      8'h45:        glyph = 7'h06;  // E
      8'h46:        glyph = 7'h0E;  // F
      8'h47:        glyph = 7'h42;  // G
      8'h48:        glyph = 7'h09;  // H
      8'h49:        glyph = 7'h4F;  // I
      8'h4A:        glyph = 7'h61;  // J
      8'h4B:        glyph = 7'h0A;  // K
      8'h4C:        glyph = 7'h47;  // L
      8'h4D:        glyph = 7'h48;  // M
      8'h4E:        glyph = 7'h2B;  // n
      8'h4F:        glyph = 7'h23;  // o
      8'h50:        glyph = 7'h0C;  // P
      8'h51:        glyph = 7'h18;  // q
      8'h52:        glyph = 7'h2F;  // r
      8'h53:        glyph = 7'h12;  // S
      8'h54:        glyph = 7'h07;  // t
      8'h55:        glyph = 7'h41;  // U
      8'h56:        glyph = 7'h63;  // v
      8'h57:        glyph = 7'h55;  // W
      8'h58:        glyph = 7'h09;  // X
      8'h59:        glyph = 7'h11;  // y
      8'h5A:        glyph = 7'h24;  // Z
      default:      glyph = 7'h7F;
    endcase
  endfunction

  assign xfer       = char_valid && ready_q;
  assign char_ready = ready_q;
  assign busy       = busy_q;
  assign hex_out    = hex_q;

  // Control and display registers; reset blanks the display immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      off_q   <= '0;
      tick_q  <= '0;
      phase_q <= 1'b0;
      mode_q  <= 2'b00;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      hex_q   <= '1;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      off_q   <= off_d;
      tick_q  <= tick_d;
      phase_q <= phase_d;
      mode_q  <= mode;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      hex_q   <= hex_d;
    end
  end

  // Message storage; contents are meaningless beyond len_q so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_q[len_q[IDX_W-1:0]] <= char_in;
    end
  end

  // Next state, buffer fill and handshake; clear overrides everything.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wr_en   = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      len_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (xfer) begin
            state_d = S_LOAD;
            len_d   = len_q + LEN_W'(1);
            wr_en   = 1'b1;
          end
        end
        S_LOAD: begin
          if (xfer) begin
            len_d = len_q + LEN_W'(1);
            wr_en = 1'b1;
          end
          if (commit) begin
            state_d = S_SHOW;
          end
        end
        S_SHOW: state_d = S_SHOW;
        default: state_d = S_IDLE;
      endcase
    end
    ready_d = (state_d == S_IDLE) ||
              ((state_d == S_LOAD) && (len_d < LEN_W'(MSG_DEPTH)));
    busy_d  = (state_d == S_SHOW);
  end

  // Scroll offset and blink phase timebase; restarts on SHOW entry or mode change.
  always_comb begin
    off_d   = off_q;
    tick_d  = tick_q;
    phase_d = phase_q;
    if ((state_q != S_SHOW) || (state_d != S_SHOW) || (mode != mode_q)) begin
      off_d   = '0;
      tick_d  = '0;
      phase_d = 1'b0;
    end else if (mode_q == MODE_SCROLL) begin
      if (tick_q == TICK_W'(CLK_DIV - 1)) begin
        tick_d = '0;
        if ((32'(off_q) + 32'd1) >= (32'(len_q) + NUM_DIGITS)) begin
          off_d = '0;
        end else begin
          off_d = off_q + OFF_W'(1);
        end
      end else begin
        tick_d = tick_q + TICK_W'(1);
      end
    end else if (mode_q == MODE_BLINK) begin
      if (tick_q == TICK_W'(BLINK_DIV - 1)) begin
        tick_d  = '0;
        phase_d = ~phase_q;
      end else begin
        tick_d = tick_q + TICK_W'(1);
      end
    end
  end

  // Render the digit row from the current registers (one cycle to hex_out).
  always_comb begin
    logic [31:0] idx;
    logic [31:0] lim;
    logic        vis;
    logic [7:0]  ch;
    hex_d = '1;
    idx   = '0;
    lim   = 32'(len_q) + NUM_DIGITS;
    vis   = 1'b0;
    ch    = '0;
    if (state_q == S_SHOW) begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        if (mode_q == MODE_SCROLL) begin
          idx = 32'(off_q) + k;
          if (idx >= lim) begin
            idx = idx - lim;
          end
        end else begin
          idx = k;
        end
        vis = (idx < 32'(len_q)) && !((mode_q == MODE_BLINK) && phase_q);
        ch  = buf_q[IDX_W'(idx)];
        if (vis) begin
          hex_d[7*(NUM_DIGITS-1-k) +: 7] = glyph(ch);
        end
      end
    end
  end

endmodule

// File: tb/tb_ascii_scroll_display.sv
// Bench for ascii_scroll_display: directed scenarios plus random sessions,
// scored against a cycle-count based reference model through a queue.
module tb_ascii_scroll_display;

  localparam int ND    = 4;
  localparam int DEPTH = 8;
  localparam int CDIV  = 4;
  localparam int BDIV  = 3;
  localparam int HW    = 7 * ND;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [7:0]    char_in = 8'h00;
  logic          char_valid = 1'b0;
  logic          commit = 1'b0;
  logic          clear = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          char_ready;
  logic          busy;
  logic [HW-1:0] hex_out;

  ascii_scroll_display #(
    .NUM_DIGITS(ND),
    .MSG_DEPTH (DEPTH),
    .CLK_DIV   (CDIV),
    .BLINK_DIV (BDIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .char_in   (char_in),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .commit    (commit),
    .clear     (clear),
    .mode      (mode),
    .hex_out   (hex_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [HW-1:0] hex;
    logic          busy;
    logic          ready;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference model: 0 = idle, 1 = loading, 2 = showing.
  int               m_state = 0;
  byte unsigned     m_msg[$];
  int               m_t = 0;       // cycles spent in SHOW since last restart
  logic [1:0]       m_mode = 2'b00;
  logic             m_ready = 1'b0;

  // Active-high segment fonts (bit0=a .. bit6=g); the display drives the inverse.
  byte unsigned font_dig [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                  8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
  byte unsigned font_let [26] = '{8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71, 8'h3D,
                                  8'h76, 8'h30, 8'h1E, 8'h75, 8'h38, 8'h37, 8'h54,
                                  8'h5C, 8'h73, 8'h67, 8'h50, 8'h6D, 8'h78, 8'h3E,
                                  8'h1C, 8'h2A, 8'h76, 8'h6E, 8'h5B};

  localparam logic [HW-1:0] HI_EXP = {7'b0001001, 7'b1001111, 7'b1111111, 7'b1111111};

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, want, $time);
  endfunction

  function automatic logic [6:0] glyph_ref(input byte unsigned c);
    byte unsigned u;
    byte unsigned f;
    u = c;
    if (u >= 8'h61 && u <= 8'h7A) u = u - 8'h20;
    if (u >= 8'h41 && u <= 8'h5A)      f = font_let[u - 8'h41];
    else if (u >= 8'h30 && u <= 8'h39) f = font_dig[u - 8'h30];
    else if (u <= 8'h09)               f = font_dig[u];
    else                               f = 8'h00;
    return ~f[6:0];
  endfunction

  // Expected digit row for the model's current state.
  function automatic logic [HW-1:0] exp_display();
    logic [HW-1:0] r;
    int            len;
    int            L;
    int            off;
    int            j;
    bit            vis;
    r = '1;
    if (m_state != 2) return r;
    len = m_msg.size();
    L   = len + ND;
    off = (m_t / CDIV) % L;
    for (int k = 0; k < ND; k++) begin
      j   = (m_mode == 2'b01) ? (off + k) % L : k;
      vis = (j < len);
      if (m_mode == 2'b10 && ((m_t / BDIV) % 2) == 1) vis = 1'b0;
      if (vis) r[7*(ND-1-k) +: 7] = glyph_ref(m_msg[j]);
    end
    return r;
  endfunction

  function automatic byte unsigned rand_char();
    case ($urandom_range(0, 5))
      0:       return 8'($urandom_range(65, 90));
      1:       return 8'($urandom_range(97, 122));
      2:       return 8'($urandom_range(48, 57));
      3:       return 8'($urandom_range(0, 9));
      4:       return 8'h20;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // Drive one cycle, advance the model across the edge, queue the expectation.
  task automatic cyc(input bit v, input byte unsigned c, input bit cm, input bit cl,
                     input logic [1:0] md);
    exp_t e;
    bit   xfer;
    int   ns;
    char_valid = v;
    char_in    = c;
    commit     = cm;
    clear      = cl;
    mode       = md;
    @(posedge clk);
    e.hex = exp_display();
    xfer  = v && m_ready;
    ns    = m_state;
    if (cl) begin
      ns = 0;
      m_msg.delete();
    end else begin
      if (xfer) m_msg.push_back(c);
      if (m_state == 0 && xfer)    ns = 1;
      else if (m_state == 1 && cm) ns = 2;
    end
    if (ns == 2) m_t = (m_state != 2 || md != m_mode) ? 0 : m_t + 1;
    else         m_t = 0;
    m_state = ns;
    m_mode  = md;
    m_ready = (m_state == 0) || (m_state == 1 && m_msg.size() < DEPTH);
    e.busy  = (m_state == 2);
    e.ready = m_ready;
    exp_q.push_back(e);
    #1;
  endtask

  // Assert reset between edges, check immediate blanking, then release.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n      = 1'b0;
    char_valid = 1'b0;
    commit     = 1'b0;
    clear      = 1'b0;
    mode       = 2'b00;
    m_state = 0;
    m_msg.delete();
    m_t     = 0;
    m_mode  = 2'b00;
    m_ready = 1'b0;
    #1;
    chk("rst_hex", 64'(hex_out), 64'({HW{1'b1}}));
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(char_ready), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare every queued expectation away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("hex_out", 64'(hex_out), 64'(e.hex));
        chk("busy", 64'(busy), 64'(e.busy));
        chk("char_ready", 64'(char_ready), 64'(e.ready));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] scroll_left [7];
    logic [6:0] want;
    logic [1:0] md;
    int         n;
    int         r;
    scroll_left = '{7'h79, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79};

    do_reset();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'b00);
    chk("ready_after_release", 64'(char_ready), 64'd1);

    // "Hi" static, commit in IDLE ignored first
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'b00);
    cyc(1'b1, 8'h48, 1'b0, 1'b0, 2'b00);
    cyc(1'b1, 8'h69, 1'b0, 1'b0, 2'b00);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'b00);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'b00);
    chk("hi_static_hex", 64'(hex_out), 64'(HI_EXP));
    chk("hi_static_busy", 64'(busy), 64'd1);
    repeat (4) cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'b00);

    // "10" scrolling, leftmost digit walks through the virtual string
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'b01);
    cyc(1'b1, 8'h31, 1'b0, 1'b0, 2'b01);
    cyc(1'b1, 8'h30, 1'b0, 1'b0, 2'b01);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'b01);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'b01);
    for (int s = 0; s < 7; s++) begin
      chk("scroll_left", 64'(hex_out[HW-1 -: 7]), 64'(scroll_left[s]));
      repeat (4) cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'b01);
    end

    // ten offers into an eight-deep buffer
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'b00);
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h41 + i), 1'b0, 1'b0, 2'b00);
    chk("full_ready", 64'(char_ready), 64'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'b00);
    chk("full_commit_busy", 64'(busy), 64'd1);
    repeat (5) cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'b00);

    // "A" blinking: 3 cycles lit, 3 cycles dark
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'b10);
    cyc(1'b1, 8'h41, 1'b0, 1'b0, 2'b10);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'b10);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'b10);
    for (int i = 0; i < 12; i++) begin
      want = (((i / 3) % 2) == 0) ? 7'h08 : 7'h7F;
      chk("blink_left", 64'(hex_out[HW-1 -: 7]), 64'(want));
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'b10);
    end

    // commit and clear together while loading
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'b00);
    cyc(1'b1, 8'h42, 1'b0, 1'b0, 2'b00);
    cyc(1'b1, 8'h43, 1'b0, 1'b0, 2'b00);
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 2'b00);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'b00);
    chk("commit_clear_busy", 64'(busy), 64'd0);
    chk("commit_clear_hex", 64'(hex_out), 64'({HW{1'b1}}));

    // reset in the middle of a scroll
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'b01);
    cyc(1'b1, 8'h41, 1'b0, 1'b0, 2'b01);
    cyc(1'b1, 8'h42, 1'b0, 1'b0, 2'b01);
    cyc(1'b1, 8'h31, 1'b0, 1'b0, 2'b01);
    cyc(1'b1, 8'h32, 1'b0, 1'b0, 2'b01);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'b01);
    repeat (9) cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'b01);
    do_reset();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'b00);
    chk("post_reset_ready", 64'(char_ready), 64'd1);
    chk("post_reset_busy", 64'(busy), 64'd0);
    cyc(1'b1, 8'h5A, 1'b0, 1'b0, 2'b00);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'b00);
    repeat (4) cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'b00);

    // random sessions
    for (int s = 0; s < 40; s++) begin
      md = 2'($urandom_range(0, 3));
      cyc(1'b0, 8'h00, 1'b0, 1'b1, md);
      n = $urandom_range(0, 11);
      for (int i = 0; i < n; i++) cyc($urandom_range(0, 3) != 0, rand_char(), 1'b0, 1'b0, md);
      case ($urandom_range(0, 7))
        0:       cyc(1'b1, rand_char(), 1'b1, 1'b1, md);
        1:       cyc(1'b0, 8'h00, 1'b0, 1'b1, md);
        default: cyc($urandom_range(0, 1) == 1, rand_char(), 1'b1, 1'b0, md);
      endcase
      r = $urandom_range(6, 30);
      for (int i = 0; i < r; i++) begin
        if ($urandom_range(0, 9) == 0) md = 2'($urandom_range(0, 3));
        cyc($urandom_range(0, 1) == 1, rand_char(), $urandom_range(0, 9) == 0, 1'b0, md);
      end
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
